// File: rtl/key_event_fifo.sv
// Key event queue: pending push/release requests are granted lowest-index first into a FIFO.
// Build option: define KEY_EVT_RELEASE_EN to queue release events as well as push events.
module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [4:0]    key_push,
  input  logic [4:0]    key_release,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [3:0]    evt_data,
  output logic [CW-1:0] evt_count,
  output logic          ovf,
  input  logic          ovf_clr
);
  localparam int AW = $clog2(DEPTH);

  logic [9:0]    r_pending;
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic [9:0]    w_pulse;
  logic [9:0]    w_sel;
  logic [9:0]    w_grant;
  logic [3:0]    w_code;
  logic          w_pop;
  logic          w_space;
  logic          w_wr;
  logic          w_ovf_set;

`ifdef KEY_EVT_RELEASE_EN
  assign w_pulse  = {key_release, key_push};
  assign evt_data = r_mem[r_rd_ptr];
`else
  logic w_unused_release;
  assign w_pulse          = {5'b00000, key_push};
  assign evt_data         = {1'b0, r_mem[r_rd_ptr][2:0]};
  assign w_unused_release = ^{key_release, r_mem[r_rd_ptr][3]};
`endif

  assign evt_valid = (r_count != {CW{1'b0}});
  assign evt_count = r_count;
  assign ovf       = r_ovf;

  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign w_pop     = evt_valid && evt_ready;
  assign w_space   = (r_count < CW'(DEPTH)) || w_pop;
  assign w_sel     = r_pending & (~r_pending + 10'd1);
  assign w_grant   = w_space ? w_sel : 10'd0;
  assign w_wr      = |w_grant;
  assign w_ovf_set = |(w_pulse & r_pending & ~w_grant);

  // Event code of the lowest pending bit: {release, key index}.
  always_comb begin
    w_code = 4'h0;
    case (w_sel)
      10'b0000000001: w_code = 4'h0;
      10'b0000000010: w_code = 4'h1;
      10'b0000000100: w_code = 4'h2;
      10'b0000001000: w_code = 4'h3;
      10'b0000010000: w_code = 4'h4;
      10'b0000100000: w_code = 4'h8;
      10'b0001000000: w_code = 4'h9;
      10'b0010000000: w_code = 4'hA;
      10'b0100000000: w_code = 4'hB;
      10'b1000000000: w_code = 4'hC;
      default:        w_code = 4'h0;
    endcase
  end

  // Control state: pending mask, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_pending <= 10'd0;
      r_wr_ptr  <= {AW{1'b0}};
      r_rd_ptr  <= {AW{1'b0}};
      r_count   <= {CW{1'b0}};
      r_ovf     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | w_pulse;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Event storage; contents are meaningful only between the pointers.
  always_ff @(posedge clk) begin
    if (clr_n && w_wr) begin
      r_mem[r_wr_ptr] <= w_code;
    end
  end

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: queue-based reference model checked every cycle, plus directed scenarios.
module tb_key_event_fifo;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef KEY_EVT_RELEASE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr_n;
  logic [4:0]    key_push;
  logic [4:0]    key_release;
  logic          evt_valid;
  logic          evt_ready;
  logic [3:0]    evt_data;
  logic [CW-1:0] evt_count;
  logic          ovf;
  logic          ovf_clr;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [3:0] mq[$];
  logic [3:0] log_q[$];
  logic [9:0] m_pend;
  logic       m_ovf;

  always #5 clk = ~clk;

  key_event_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .clr_n(clr_n), .key_push(key_push), .key_release(key_release),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_count(evt_count), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  function automatic logic [3:0] ev_code(input int b);
    return (b >= 5) ? 4'(8 + b - 5) : 4'(b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: queue of events plus a set of pending requests.
  always @(posedge clk) begin : model_step
    logic [9:0] pulses;
    int  g;
    bit  pop;
    bit  space;
    bit  ovfset;
    pulses = {(REL_EN ? key_release : 5'b00000), key_push};
    if (!clr_n) begin
      mq.delete();
      m_pend = 10'd0;
      m_ovf  = 1'b0;
    end else begin
      pop   = (mq.size() != 0) && evt_ready;
      space = (mq.size() < DEPTH) || pop;
      g = -1;
      if (space) begin
        for (int b = 0; b < 10; b++) if (m_pend[b] && g < 0) g = b;
      end
      ovfset = 1'b0;
      for (int b = 0; b < 10; b++) if (pulses[b] && m_pend[b] && b != g) ovfset = 1'b1;
      if (pop) log_q.push_back(mq.pop_front());
      if (g >= 0) begin
        mq.push_back(ev_code(g));
        m_pend[g] = 1'b0;
      end
      m_pend = m_pend | pulses;
      if (ovfset) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("evt_valid", evt_valid, mq.size() != 0);
      chk("evt_count", evt_count, mq.size());
      chk("ovf", ovf, m_ovf);
      if (mq.size() != 0) chk("evt_data", evt_data, mq[0]);
    end
  end

  initial begin : stim
    logic [3:0] exp_t2 [3];
    logic [3:0] exp_t3 [10];
    int n1;
    exp_t2 = '{4'h0, 4'h4, 4'h9};
    exp_t3 = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};

    clr_n = 1'b0; key_push = 5'b0; key_release = 5'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("reset_valid", evt_valid, 1'b0);
    chk("reset_count", evt_count, 0);
    chk("reset_ovf", ovf, 1'b0);
    clr_n = 1'b1;
    tick();

    // single push, two-cycle latency
    key_push = 5'b00100; tick(); key_push = 5'b0;
    chk("t1_valid_n1", evt_valid, 1'b0);
    tick();
    chk("t1_valid_n2", evt_valid, 1'b1);
    chk("t1_data", evt_data, 4'b0010);
    chk("t1_count", evt_count, 1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("t1_count_pop", evt_count, 0);

    // simultaneous pushes and release, priority order
    log_q.delete();
    evt_ready = 1'b1; key_push = 5'b10001; key_release = 5'b00010;
    tick();
    key_push = 5'b0; key_release = 5'b0;
    repeat (6) tick();
    evt_ready = 1'b0;
    chk("t2_n", log_q.size(), REL_EN ? 3 : 2);
    for (int i = 0; i < 3; i++) if (i < log_q.size()) chk("t2_event", log_q[i], exp_t2[i]);
    chk("t2_valid", evt_valid, 1'b0);
    chk("t2_ovf", ovf, 1'b0);

    // overfill: pending bits held while full, then drained in order
    log_q.delete();
    key_push = 5'b11111; key_release = 5'b11111;
    tick();
    key_push = 5'b0; key_release = 5'b0;
    repeat (12) tick();
    chk("t3_count", evt_count, REL_EN ? 8 : 5);
    chk("t3_pending", $countones(m_pend), REL_EN ? 2 : 0);
    chk("t3_ovf", ovf, 1'b0);
    evt_ready = 1'b1; repeat (14) tick(); evt_ready = 1'b0;
    chk("t3_n", log_q.size(), REL_EN ? 10 : 5);
    for (int i = 0; i < 10; i++) if (i < log_q.size()) chk("t3_event", log_q[i], exp_t3[i]);

    // merge on full FIFO sets ovf, clear afterwards
    log_q.delete();
    key_push = 5'b11101; tick(); key_push = 5'b0; repeat (5) tick();
    key_push = 5'b11101; tick(); key_push = 5'b0; repeat (5) tick();
    chk("t4_full", evt_count, 8);
    key_push = 5'b00010; tick(); key_push = 5'b0; tick();
    key_push = 5'b00010; tick(); key_push = 5'b0;
    chk("t4_ovf_set", ovf, 1'b1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("t4_ovf_clr", ovf, 1'b0);
    evt_ready = 1'b1; repeat (12) tick(); evt_ready = 1'b0;
    n1 = 0;
    foreach (log_q[i]) if (log_q[i] == 4'h1) n1++;
    chk("t4_key1_once", n1, 1);
    chk("t4_n", log_q.size(), 9);

    // reset mid-operation drops stored and pending events
    log_q.delete();
    key_push = 5'b11111; tick(); key_push = 5'b0; repeat (5) tick();
    chk("t5_count5", evt_count, 5);
    key_push = 5'b00011; tick(); key_push = 5'b0;
    chk("t5_pending", $countones(m_pend), 2);
    clr_n = 1'b0; key_push = 5'b00100; evt_ready = 1'b1;
    tick();
    clr_n = 1'b1; key_push = 5'b0; evt_ready = 1'b0;
    chk("t5_count", evt_count, 0);
    chk("t5_valid", evt_valid, 1'b0);
    chk("t5_ovf", ovf, 1'b0);
    evt_ready = 1'b1; repeat (8) tick(); evt_ready = 1'b0;
    chk("t5_no_stale", log_q.size(), 0);
    chk("t5_valid_after", evt_valid, 1'b0);

    // releases only
    key_release = 5'b11111; tick(); key_release = 5'b0;
    repeat (6) tick();
    chk("t6_release_count", evt_count, REL_EN ? 5 : 0);
    clr_n = 1'b0; tick(); clr_n = 1'b1;

    // randomized traffic, low then high consumer rate
    for (int c = 0; c < 3000; c++) begin
      key_push    = ($urandom % 3 == 0) ? 5'($urandom) : 5'b0;
      key_release = ($urandom % 3 == 0) ? 5'($urandom) : 5'b0;
      evt_ready   = (c < 1500) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
      ovf_clr     = ($urandom % 16 == 0);
      clr_n       = ($urandom % 300 != 0);
      tick();
    end
    key_push = 5'b0; key_release = 5'b0; evt_ready = 1'b0; ovf_clr = 1'b0; clr_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
